pio_input_filter: RTL and testbench
===================================

PIO_INPUT_FILTER -- requirements
Module: pio_input_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: number of input channels.
REQ-002 The block SHALL have parameter PRESCALE, default 1000: clocks per filter tick, legal range 1..65536.
REQ-003 The block SHALL have parameter FILTER_LEN, default 4: consecutive ticks an input must differ before acceptance, legal range 1..255.
REQ-004 The block SHALL have parameter RESET_LEVEL, default 1'b0: level loaded into every channel's synchronizer and out_level at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port raw_in, input, WIDTH bits: asynchronous external inputs.
REQ-008 The block SHALL have port out_level, output, WIDTH bits: registered debounced levels that drive the PIO in_port.
REQ-009 The block SHALL have port out_change, output, WIDTH bits: one-clock pulse per bit when that out_level bit toggles.
REQ-010 The block SHALL have port tick, output, 1 bit: one-clock prescaler strobe.

Function
REQ-011 Each raw_in bit SHALL pass through a 2-FF synchronizer (sync1, then sync2) before any other use.
REQ-012 The prescaler SHALL count 0..PRESCALE-1, assert tick in the cycle count==PRESCALE-1, and wrap to 0; PRESCALE=1 SHALL give tick permanently high after reset.
REQ-013 Each channel SHALL implement FSM STABLE/PENDING with an 8-bit tick counter cnt.
REQ-014 STABLE->PENDING SHALL occur when sync2!=out_level, clearing cnt; the entry cycle's tick SHALL NOT count.
REQ-015 In PENDING, each tick with sync2!=out_level SHALL increment cnt; on the tick where cnt reaches FILTER_LEN, out_level SHALL load sync2 and the FSM SHALL return to STABLE.
REQ-016 In PENDING, any cycle with sync2==out_level SHALL return the FSM to STABLE without updating out_level (glitch rejected); this SHALL take priority over a coincident final tick.
REQ-017 out_change[i] SHALL be high in exactly the cycle after the edge on which out_level[i] changes, and low otherwise.
REQ-018 With PRESCALE=1, if raw_in changes between clock edges 0 and 1, out_level SHALL update at edge 3+FILTER_LEN.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several bits SHALL each be filtered separately.
REQ-020 out_level SHALL never toggle more than once per FILTER_LEN ticks per channel.

Reset
REQ-021 reset_n low SHALL asynchronously set sync1, sync2, and out_level to RESET_LEVEL on all bits; out_change, tick, the prescaler count, and all cnt to 0; and all FSMs to STABLE.
REQ-022 Reset asserted mid-PENDING SHALL discard the pending transition; after release, filtering SHALL restart from RESET_LEVEL.
REQ-023 The first tick after reset release SHALL occur PRESCALE clocks after the first active edge.

Configuration
REQ-024 With macro PIO_INPUT_FILTER_GLITCH_CNT_EN defined, the block SHALL add input glitch_clr (1 bit) and output glitch_count (16 bits).
REQ-025 glitch_count SHALL increment by 1 in each cycle in which at least one channel takes the REQ-016 reject path, and SHALL saturate at 0xFFFF.
REQ-026 glitch_clr high SHALL zero glitch_count on the next edge; glitch_clr SHALL have priority over a coincident increment.
REQ-027 glitch_count SHALL reset to 0.
REQ-028 Without the macro, those ports and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: PRESCALE=1, FILTER_LEN=4, raw_in[0] 0->1 held -> out_level[0]=1 at edge 7; out_change[0] pulses once.
REQ-030 Scenario: PRESCALE=1, FILTER_LEN=4, raw_in[5] high for 3 clocks then low -> out_level[5] stays 0; glitch_count=1 (macro on).
REQ-031 Scenario: PRESCALE=10, FILTER_LEN=2, raw_in=0xFFFF0000 held -> bits 31:16 rise together after 2 counted ticks; bits 15:0 stay 0.
REQ-032 Scenario: reset_n pulsed low while raw_in[3] is PENDING at cnt=2 -> out_level[3]=RESET_LEVEL; the FSM restarts, and the update arrives a full FILTER_LEN ticks later.
REQ-033 Scenario: sync2 returns to out_level on the same cycle as the final tick -> no out_level update, FSM STABLE.
REQ-034 Scenario: force glitch_count to 0xFFFF, inject a glitch -> glitch_count holds 0xFFFF; glitch_clr with a coincident glitch -> 0.

Source files
------------

// File: rtl/pio_input_filter.sv
// Debounce filter for PIO inputs: 2-FF synchronizer plus per-channel tick-counted STABLE/PENDING filter.
// Define PIO_INPUT_FILTER_GLITCH_CNT_EN to add glitch_clr / glitch_count (rejected-glitch counter).
module pio_input_filter_lane #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic change_o
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  ,
  output logic glitch_o
`endif
);
  typedef enum logic {STABLE, PENDING} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       chg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      chg_q   <= level_d ^ level_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A return to the accepted level wins over a coincident final tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE: begin
        if (sync2_q != level_q) begin
          state_d = PENDING;
          cnt_d   = '0;
        end
      end
      PENDING: begin
        if (sync2_q == level_q) begin
          state_d = STABLE;
        end else if (tick_i) begin
          if ({1'b0, cnt_q} + 9'd1 == 9'(FILTER_LEN)) begin
            level_d = sync2_q;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign level_o  = level_q;
  assign change_o = chg_q;
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  assign glitch_o = (state_q == PENDING) && (sync2_q == level_q);
`endif
endmodule

module pio_input_filter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned FILTER_LEN  = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] out_change,
  output logic             tick
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  ,
  input  logic             glitch_clr,
  output logic [15:0]      glitch_count
`endif
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;
  logic          tick_q;

  // Registered strobe: with PRESCALE=1 it sits high from the first edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pcnt_q == PMAX);
      pcnt_q <= (pcnt_q == PMAX) ? '0 : pcnt_q + PW'(1);
    end
  end

  assign tick = tick_q;

`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_input_filter_lane #(
      .FILTER_LEN (FILTER_LEN),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (raw_in[i]),
      .tick_i  (tick_q),
      .level_o (out_level[i]),
      .change_o(out_change[i])
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
      ,
      .glitch_o(glitch[i])
`endif
    );
  end

`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  logic [15:0] glitch_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  glitch_cnt_q <= '0;
    else if (glitch_clr)                           glitch_cnt_q <= '0;
    else if (|glitch && glitch_cnt_q != 16'hFFFF)  glitch_cnt_q <= glitch_cnt_q + 16'd1;
  end

  assign glitch_count = glitch_cnt_q;
`endif
endmodule

// File: tb/tb_pio_input_filter.sv
// Scoreboard bench: dut_a (PRESCALE=1, FILTER_LEN=4) and dut_b (PRESCALE=10, FILTER_LEN=2).
module tb_pio_input_filter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_a, raw_b, lvl_a, chg_a, lvl_b, chg_b;
  logic         tick_a, tick_b;
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
  logic         gclr_a, gclr_b;
  logic [15:0]  gcnt_a, gcnt_b;
`endif

  pio_input_filter #(.WIDTH(W), .PRESCALE(1), .FILTER_LEN(4), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_a),
    .out_level(lvl_a), .out_change(chg_a), .tick(tick_a)
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    , .glitch_clr(gclr_a), .glitch_count(gcnt_a)
`endif
  );

  pio_input_filter #(.WIDTH(W), .PRESCALE(10), .FILTER_LEN(2), .RESET_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_b),
    .out_level(lvl_b), .out_change(chg_b), .tick(tick_b)
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    , .glitch_clr(gclr_b), .glitch_count(gcnt_b)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] lvl;
    logic [W-1:0] chg;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  // Monitors: every out_change pulse must match the next expected update.
  always @(negedge clk) begin
    if (chg_a != '0) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: change %h level %h at cyc %0d, expected no change", chg_a, lvl_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("a_cyc", 32'(cyc), 32'(e_a.cyc));
        chk("a_chg", chg_a, e_a.chg);
        chk("a_lvl", lvl_a, e_a.lvl);
      end
    end
  end

  always @(negedge clk) begin
    if (chg_b != '0) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: change %h level %h at cyc %0d, expected no change", chg_b, lvl_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("b_cyc", 32'(cyc), 32'(e_b.cyc));
        chk("b_chg", chg_b, e_b.chg);
        chk("b_lvl", lvl_b, e_b.lvl);
      end
    end
  end

  initial begin
    int n, base;
    logic [W-1:0] exp_a;
    reset_n = 1'b0;
    raw_a   = '0;
    raw_b   = '0;
    exp_a   = '0;
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    gclr_a = 1'b0;
    gclr_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_lvl_a",  lvl_a, 32'h0);
    chk("rst_chg_a",  chg_a, 32'h0);
    chk("rst_tick_a", 32'(tick_a), 32'h0);
    chk("rst_lvl_b",  lvl_b, 32'h0);
    chk("rst_tick_b", 32'(tick_b), 32'h0);
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    chk("rst_gcnt", 32'(gcnt_a), 32'h0);
`endif

    // Release; edge k after release has cyc == base+k.
    reset_n = 1'b1;
    base = cyc;
    @(negedge clk);
    chk("tick_a_first", 32'(tick_a), 32'h1);
    while (cyc < base + 9) @(negedge clk);
    chk("tick_b_pre", 32'(tick_b), 32'h0);
    @(negedge clk);
    chk("tick_b_first", 32'(tick_b), 32'h1);
    @(negedge clk);
    chk("tick_b_off", 32'(tick_b), 32'h0);

    // dut_b: PENDING at edge 23, ticks sampled at edges 31 and 41.
    while (cyc < base + 20) @(negedge clk);
    raw_b = 32'hFFFF_0000;
    q_b.push_back('{base + 41, 32'hFFFF_0000, 32'hFFFF_0000});
    while (cyc < base + 45) @(negedge clk);
    chk("b_halves", lvl_b, 32'hFFFF_0000);

    // Single rise on bit 0: update at edge n+7.
    n = cyc;
    raw_a[0] = 1'b1;
    exp_a = 32'h1;
    q_a.push_back('{n + 7, exp_a, 32'h1});
    repeat (12) @(negedge clk);

    // Bit 5 high 3 clocks: rejected at cnt=2.
    raw_a[5] = 1'b1;
    repeat (3) @(negedge clk);
    raw_a[5] = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch3_lvl", lvl_a, exp_a);
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    chk("gcnt_1", 32'(gcnt_a), 32'h1);
`endif

    // Bit 6 high 4 clocks: falls back on the same edge as the final tick.
    raw_a[6] = 1'b1;
    repeat (4) @(negedge clk);
    raw_a[6] = 1'b0;
    repeat (8) @(negedge clk);
    chk("final_tick_lvl", lvl_a, exp_a);
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    chk("gcnt_2", 32'(gcnt_a), 32'h2);
`endif

    // Bit 7 high 5 clocks: accepted, then the fall takes another full filter.
    n = cyc;
    raw_a[7] = 1'b1;
    q_a.push_back('{n + 7,  exp_a | 32'h80, 32'h80});
    q_a.push_back('{n + 12, exp_a,          32'h80});
    repeat (5) @(negedge clk);
    raw_a[7] = 1'b0;
    repeat (12) @(negedge clk);

    // Independent channels: bit0 falls, bits 1,2,9 rise together; bit 10 two clocks later.
    n = cyc;
    raw_a = 32'h0000_0206;
    exp_a = 32'h0000_0206;
    q_a.push_back('{n + 7, exp_a, 32'h0000_0207});
    repeat (2) @(negedge clk);
    raw_a = 32'h0000_0606;
    exp_a = 32'h0000_0606;
    q_a.push_back('{n + 9, exp_a, 32'h0000_0400});
    repeat (12) @(negedge clk);
    chk("multi_lvl", lvl_a, 32'h0000_0606);

`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    gclr_a = 1'b1;
    @(negedge clk);
    gclr_a = 1'b0;
    chk("gclr", 32'(gcnt_a), 32'h0);
    // Glitch reject lands on edge n+6; clear is sampled on that same edge.
    n = cyc;
    raw_a[5] = 1'b1;
    repeat (3) @(negedge clk);
    raw_a[5] = 1'b0;
    repeat (2) @(negedge clk);
    gclr_a = 1'b1;
    @(negedge clk);
    gclr_a = 1'b0;
    chk("gclr_prio", 32'(gcnt_a), 32'h0);
    repeat (4) @(negedge clk);
    force dut_a.glitch_cnt_q = 16'hFFFF;
    #1;
    release dut_a.glitch_cnt_q;
    raw_a[5] = 1'b1;
    repeat (3) @(negedge clk);
    raw_a[5] = 1'b0;
    repeat (6) @(negedge clk);
    chk("gcnt_sat", 32'(gcnt_a), 32'h0000_FFFF);
`endif

    // Bit 3 PENDING at cnt=2 (after edge n+5) when reset hits.
    n = cyc;
    raw_a = 32'h0000_060E;
    while (cyc < n + 5) @(negedge clk);
    reset_n = 1'b0;
    raw_a   = 32'h0000_0008;
    #1;
    chk("async_rst_lvl_a", lvl_a, 32'h0);
    chk("async_rst_lvl_b", lvl_b, 32'h0);
`ifdef PIO_INPUT_FILTER_GLITCH_CNT_EN
    chk("rst_gcnt2", 32'(gcnt_a), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    n = cyc;
    q_a.push_back('{n + 7,  32'h0000_0008, 32'h0000_0008});
    q_b.push_back('{n + 21, 32'hFFFF_0000, 32'hFFFF_0000});
    repeat (6) @(negedge clk);
    chk("rst_restart_pend", lvl_a, 32'h0);
    repeat (20) @(negedge clk);
    chk("rst_restart_a", lvl_a, 32'h0000_0008);
    chk("rst_restart_b", lvl_b, 32'hFFFF_0000);

    while (q_a.size() > 0) begin
      e_a = q_a.pop_front();
      n_tests++; n_fail++;
      $display("FAIL a_missing: no update seen, expected change %h at cyc %0d", e_a.chg, e_a.cyc);
    end
    while (q_b.size() > 0) begin
      e_b = q_b.pop_front();
      n_tests++; n_fail++;
      $display("FAIL b_missing: no update seen, expected change %h at cyc %0d", e_b.chg, e_b.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
